tlb_refill_walker: RTL and testbench

Miss-handling sequencer in front of the `TLB` write port. It accepts TLB-miss requests from `port_count` lookup clients and arbitrates them round-robin. For each granted miss it reads the page-table entry over a valid/ready memory port, then either writes the translation into the TLB or reports a page fault. It sits between the fetch/LSU lookup ports, the TLB, and the memory-request mux.

---
 rtl/tlb_refill_walker_pkg.sv | 35 +++
 rtl/tlb_refill_walker_rr_arbiter.sv | 27 ++
 rtl/tlb_refill_walker.sv | 175 +++++++++++++++++
 tb/tb_tlb_refill_walker.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_refill_walker_pkg.sv
// Shared parameters, walker state encoding and the PTE address helper
// for the TLB refill walker and its arbiter.
package tlb_refill_walker_pkg;

    localparam int ram_address_width = 32;
    localparam int page_offset_bits  = 12;
    localparam int bit_count         = 32;

    // Page-number width and byte shift from a page number to its PTE.
    localparam int PW        = ram_address_width - page_offset_bits;
    localparam int pte_shift = $clog2(bit_count / 8);

    // Position of the V bit inside a page-table entry.
    localparam int pte_valid_bit = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        FAULT = 3'd4
    } walker_state_t;

    // PTE byte address: base plus zero-extended page number scaled by the
    // PTE size; the sum wraps naturally at the address width.
    function automatic logic [ram_address_width-1:0] pte_address(
        input logic [ram_address_width-1:0] base,
        input logic [PW-1:0]                vpn
    );
        logic [ram_address_width-1:0] vpn_ext;
        vpn_ext = {{(ram_address_width - PW){1'b0}}, vpn};
        return base + (vpn_ext << pte_shift);
    endfunction

endpackage

// File: rtl/tlb_refill_walker_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted index and wraps, so the most recent winner has lowest priority.
module rr_arbiter #(
    parameter  int n  = 2,
    localparam int IW = (n > 1) ? $clog2(n) : 1
) (
    input  logic [n-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    // Pick the first requester found after 'last' in circular order.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = {IW{1'b0}};
        for (int i = 1; i <= n; i++) begin
            if (!grant_valid && req[(int'(last) + i) % n]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(last) + i) % n);
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/tlb_refill_walker.sv
// TLB miss sequencer: arbitrates miss clients round-robin, fetches one PTE
// per walk over a valid/ready memory port, then writes the TLB (completing
// every client waiting on the same page) or reports a fault to the owner.
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
#(
    parameter  int port_count = 2,
    localparam int GW = (port_count > 1) ? $clog2(port_count) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_valid [0:port_count-1],
    input  logic [PW-1:0]                miss_vpn   [0:port_count-1],
    output logic                         miss_done  [0:port_count-1],
    output logic                         miss_fault [0:port_count-1],
    input  logic [ram_address_width-1:0] ptbr,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    output logic [ram_address_width-1:0] mem_req_addr,
    input  logic                         mem_resp_valid,
    input  logic [bit_count-1:0]         mem_resp_data,
    output logic                         tlb_write_enable,
    output logic [PW-1:0]                tlb_key,
    output logic [PW-1:0]                tlb_value,
    output logic                         tlb_read_stall,
    output logic                         busy
);

    walker_state_t                state_q, state_d;
    logic [GW-1:0]                last_q, last_d;
    logic [GW-1:0]                grant_q, grant_d;
    logic [PW-1:0]                vpn_q, vpn_d;
    logic [ram_address_width-1:0] addr_q, addr_d;
    logic [PW-1:0]                ppn_q, ppn_d;

    logic [port_count-1:0]        req_vec_s;
    logic                         grant_valid_s;
    logic [GW-1:0]                grant_idx_s;

    // Only the V bit and the PPN field of a PTE matter to the walker.
    logic                         unused_resp_bits_s;
    assign unused_resp_bits_s = ^mem_resp_data;

    // Pack the per-client request levels for the arbiter.
    always_comb begin
        req_vec_s = {port_count{1'b0}};
        for (int k = 0; k < port_count; k++) begin
            req_vec_s[k] = miss_valid[k];
        end
    end

    rr_arbiter #(
        .n (port_count)
    ) u_arb (
        .req         (req_vec_s),
        .last        (last_q),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Walk sequencing: grant and latch in IDLE, hold the request until the
    // handshake, classify the PTE on response, one-cycle WRITE/FAULT.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        vpn_d   = vpn_q;
        addr_d  = addr_q;
        ppn_d   = ppn_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    state_d = REQ;
                    grant_d = grant_idx_s;
                    last_d  = grant_idx_s;
                    vpn_d   = miss_vpn[grant_idx_s];
                    // Address is frozen here so it stays stable under backpressure.
                    addr_d  = pte_address(ptbr, miss_vpn[grant_idx_s]);
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    if (mem_resp_data[pte_valid_bit]) begin
                        ppn_d   = mem_resp_data[page_offset_bits +: PW];
                        state_d = WRITE;
                    end else begin
                        state_d = FAULT;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            WRITE:   state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Walker registers; reset parks last_grant on the highest port so port 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= GW'(port_count - 1);
            grant_q <= {GW{1'b0}};
            vpn_q   <= {PW{1'b0}};
            addr_q  <= {ram_address_width{1'b0}};
            ppn_q   <= {PW{1'b0}};
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            vpn_q   <= vpn_d;
            addr_q  <= addr_d;
            ppn_q   <= ppn_d;
        end
    end

    // Outputs decoded from the state register; done also covers waiting
    // clients whose page matches the one just written.
    always_comb begin
        mem_req_valid    = 1'b0;
        mem_req_addr     = {ram_address_width{1'b0}};
        tlb_write_enable = 1'b0;
        tlb_key          = {PW{1'b0}};
        tlb_value        = {PW{1'b0}};
        for (int k = 0; k < port_count; k++) begin
            miss_done[k]  = 1'b0;
            miss_fault[k] = 1'b0;
        end
        case (state_q)
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = addr_q;
            end
            WRITE: begin
                tlb_write_enable = 1'b1;
                tlb_key          = vpn_q;
                tlb_value        = ppn_q;
                for (int k = 0; k < port_count; k++) begin
                    if (k == int'(grant_q)) begin
                        miss_done[k] = 1'b1;
                    end else if (miss_valid[k] && (miss_vpn[k] == vpn_q)) begin
                        miss_done[k] = 1'b1;
                    end else begin
                        miss_done[k] = 1'b0;
                    end
                end
            end
            FAULT: begin
                for (int k = 0; k < port_count; k++) begin
                    if (k == int'(grant_q)) begin
                        miss_fault[k] = 1'b1;
                    end else begin
                        miss_fault[k] = 1'b0;
                    end
                end
            end
            default: begin
                mem_req_valid = 1'b0;
            end
        endcase
        tlb_read_stall = tlb_write_enable;
        busy           = (state_q != IDLE);
    end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Self-checking bench for tlb_refill_walker: a cycle-stepped reference
// model of the walk protocol plus a PTE memory and miss clients.
module tb_tlb_refill_walker;
    import tlb_refill_walker_pkg::*;

    localparam int P = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_valid [0:P-1];
    logic [PW-1:0] miss_vpn   [0:P-1];
    logic          miss_done  [0:P-1];
    logic          miss_fault [0:P-1];
    logic [31:0]   ptbr;
    logic          mem_req_valid, mem_req_ready;
    logic [31:0]   mem_req_addr;
    logic          mem_resp_valid;
    logic [31:0]   mem_resp_data;
    logic          tlb_write_enable, tlb_read_stall, busy;
    logic [PW-1:0] tlb_key, tlb_value;

    always #5 clk = ~clk;

    tlb_refill_walker #(.port_count(P)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_vpn(miss_vpn),
        .miss_done(miss_done), .miss_fault(miss_fault),
        .ptbr(ptbr),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .tlb_write_enable(tlb_write_enable), .tlb_key(tlb_key), .tlb_value(tlb_value),
        .tlb_read_stall(tlb_read_stall), .busy(busy)
    );

    int passed = 0;
    int total  = 0;
    int step_no = 0;

    // reference model state
    bit m_free, m_release_pending, m_req_pending, m_req_phase;
    int m_last, m_g;
    logic [PW-1:0] m_vpn, m_ppn;
    logic [31:0]   m_addr;
    bit armed, pulse_expected, pulse_valid_pte;
    int wait_cnt, pulse_step, stall_cnt;
    logic [31:0] armed_data;

    // configuration
    bit rand_mode = 0, stray_en = 0, auto_rereq = 0, force_en = 0, force_stray = 0;
    logic [31:0] force_data = 32'h0, cfg_ptbr = 32'h0;
    int resp_delay = 0, cfg_stall = 0, seq = 0;
    bit pend_raise [P];
    logic [PW-1:0] pend_vpn [P];

    // observations of DUT behaviour
    int obs_reads, obs_we, obs_we_step, obs_done_both, obs_req_cycles;
    int obs_done [P];
    int obs_fault [P];
    logic [31:0] obs_addr;
    logic [PW-1:0] obs_key, obs_value;
    int done_order [$];

    function automatic logic [31:0] mem_pte(input logic [31:0] a);
        return ((a >> 2) * 32'h9E37_79B1) ^ (a >> 5);
    endfunction

    function automatic logic [PW-1:0] rand_vpn();
        case ($urandom_range(0, 3))
            0:       return 20'h00010;
            1:       return 20'h00011;
            2:       return 20'hFFFFF;
            default: return PW'($urandom);
        endcase
    endfunction

    function automatic int rr_pick(input int last);
        for (int i = 1; i <= P; i++) begin
            int c;
            c = (last + i) % P;
            if (miss_valid[c] === 1'b1) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_free = 1; m_release_pending = 0; m_req_pending = 0; m_req_phase = 0;
        m_last = P - 1; m_g = -1; armed = 0; pulse_expected = 0; stall_cnt = 0;
        for (int k = 0; k < P; k++) begin
            miss_valid[k] = 1'b0; pend_raise[k] = 0;
        end
    endtask

    task automatic clear_obs();
        obs_reads = 0; obs_we = 0; obs_we_step = -1; obs_done_both = 0; obs_req_cycles = 0;
        obs_addr = 32'h0; obs_key = '0; obs_value = '0;
        for (int k = 0; k < P; k++) begin obs_done[k] = 0; obs_fault[k] = 0; end
        done_order.delete();
    endtask

    task automatic raise(input int k, input logic [PW-1:0] v);
        pend_raise[k] = 1; pend_vpn[k] = v;
    endtask

    // One clock: check outputs against the model at the negedge, then drive.
    task automatic step();
        bit hit, exp_we, exp_flt;
        bit exp_d [P];
        bit exp_f [P];
        bit drop [P];
        int g;
        @(negedge clk);
        step_no++;
        if (m_release_pending) begin m_release_pending = 0; m_free = 1; end
        if (m_req_pending) begin m_req_pending = 0; m_req_phase = 1; end
        hit     = pulse_expected && (step_no == pulse_step);
        exp_we  = hit && pulse_valid_pte;
        exp_flt = hit && !pulse_valid_pte;
        total++;
        if (tlb_write_enable !== exp_we) $display("FAIL tlb_write_enable step %0d: got %b want %b", step_no, tlb_write_enable, exp_we);
        else passed++;
        total++;
        if (tlb_read_stall !== exp_we) $display("FAIL tlb_read_stall step %0d: got %b want %b", step_no, tlb_read_stall, exp_we);
        else passed++;
        total++;
        if (busy !== !m_free) $display("FAIL busy step %0d: got %b want %b", step_no, busy, !m_free);
        else passed++;
        total++;
        if (mem_req_valid !== m_req_phase) $display("FAIL mem_req_valid step %0d: got %b want %b", step_no, mem_req_valid, m_req_phase);
        else passed++;
        if (m_req_phase) begin
            total++;
            if (mem_req_addr !== m_addr) $display("FAIL mem_req_addr step %0d: got %h want %h", step_no, mem_req_addr, m_addr);
            else passed++;
        end
        if (exp_we) begin
            total++;
            if (tlb_key !== m_vpn) $display("FAIL tlb_key step %0d: got %h want %h", step_no, tlb_key, m_vpn);
            else passed++;
            total++;
            if (tlb_value !== m_ppn) $display("FAIL tlb_value step %0d: got %h want %h", step_no, tlb_value, m_ppn);
            else passed++;
        end
        for (int k = 0; k < P; k++) begin
            exp_d[k] = exp_we && ((k == m_g) || (miss_valid[k] === 1'b1 && miss_vpn[k] == m_vpn));
            exp_f[k] = exp_flt && (k == m_g);
            drop[k]  = exp_d[k] || exp_f[k];
            total++;
            if (miss_done[k] !== exp_d[k]) $display("FAIL miss_done[%0d] step %0d: got %b want %b", k, step_no, miss_done[k], exp_d[k]);
            else passed++;
            total++;
            if (miss_fault[k] !== exp_f[k]) $display("FAIL miss_fault[%0d] step %0d: got %b want %b", k, step_no, miss_fault[k], exp_f[k]);
            else passed++;
            if (miss_done[k] === 1'b1) begin obs_done[k]++; done_order.push_back(k); end
            if (miss_fault[k] === 1'b1) obs_fault[k]++;
        end
        if (miss_done[0] === 1'b1 && miss_done[1] === 1'b1) obs_done_both++;
        if (tlb_write_enable === 1'b1) begin
            obs_we++; obs_we_step = step_no; obs_key = tlb_key; obs_value = tlb_value;
        end
        if (mem_req_valid === 1'b1) obs_req_cycles++;
        if (hit) begin pulse_expected = 0; m_release_pending = 1; end

        // clients
        for (int k = 0; k < P; k++) begin
            if (drop[k]) miss_valid[k] = 1'b0;
            if (pend_raise[k]) begin
                miss_valid[k] = 1'b1; miss_vpn[k] = pend_vpn[k]; pend_raise[k] = 0;
            end else if (miss_valid[k] !== 1'b1 && (auto_rereq || (rand_mode && $urandom_range(0, 2) == 0))) begin
                miss_valid[k] = 1'b1;
                miss_vpn[k]   = auto_rereq ? PW'(k * 4096 + seq) : rand_vpn();
                seq = (seq + 1) % 4096;
            end
        end
        ptbr = rand_mode ? $urandom : cfg_ptbr;

        // memory request side
        if (m_req_phase && stall_cnt > 0) begin
            mem_req_ready = 1'b0; stall_cnt--;
        end else begin
            mem_req_ready = 1'b1;
        end
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom;
        if (armed) begin
            if (wait_cnt == 0) begin
                mem_resp_valid = 1'b1; mem_resp_data = armed_data; armed = 0;
            end else begin
                wait_cnt--;
            end
        end else if (force_stray || (stray_en && $urandom_range(0, 2) == 0)) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F001;
        end
        if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
            obs_reads++; obs_addr = mem_req_addr;
        end
        if (m_req_phase && mem_req_ready) begin
            m_req_phase = 0;
            armed = 1;
            wait_cnt = rand_mode ? $urandom_range(0, 2) : resp_delay;
            armed_data = force_en ? force_data : mem_pte(m_addr);
            pulse_expected = 1;
            pulse_step = step_no + 2 + wait_cnt;
            pulse_valid_pte = armed_data[0];
            m_ppn = PW'(armed_data >> page_offset_bits);
        end

        // arbitration when the modelled walker is idle
        g = rr_pick(m_last);
        if (m_free && rst === 1'b1 && g >= 0) begin
            m_g = g; m_last = g; m_vpn = miss_vpn[g];
            m_addr = 32'(longint'(ptbr) + longint'(miss_vpn[g]) * 4);
            m_free = 0; m_req_pending = 1;
            stall_cnt = rand_mode ? $urandom_range(0, 3) : cfg_stall;
        end
    endtask

    function automatic bit quiet();
        bit q;
        q = m_free && !m_req_pending && !m_req_phase && !armed && !pulse_expected && !m_release_pending;
        for (int k = 0; k < P; k++) q = q && (miss_valid[k] !== 1'b1) && !pend_raise[k];
        return q;
    endfunction

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (quiet()) break;
            step();
        end
        total++;
        if (!quiet()) $display("FAIL walk_timeout step %0d: got busy after %0d cycles, want idle", step_no, budget);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b0; ptbr = 32'h0; mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
        for (int k = 0; k < P; k++) miss_vpn[k] = '0;
        model_reset();
        repeat (2) @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); else passed++;
        total++; if (mem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 0", mem_req_addr); else passed++;
        total++; if (tlb_write_enable !== 1'b0) $display("FAIL reset_tlb_we: got %b want 0", tlb_write_enable); else passed++;
        total++; if (tlb_key !== '0 || tlb_value !== '0) $display("FAIL reset_tlb_kv: got %h/%h want 0/0", tlb_key, tlb_value); else passed++;
        total++; if (busy !== 1'b0 || tlb_read_stall !== 1'b0) $display("FAIL reset_busy_stall: got %b/%b want 0/0", busy, tlb_read_stall); else passed++;
        for (int k = 0; k < P; k++) begin
            total++;
            if (miss_done[k] !== 1'b0 || miss_fault[k] !== 1'b0) $display("FAIL reset_pulses[%0d]: got %b/%b want 0/0", k, miss_done[k], miss_fault[k]);
            else passed++;
        end
        rst = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_single_miss();
        int start;
        clear_obs();
        cfg_ptbr = 32'h8000_0000; force_en = 1; force_data = 32'hAABA_0001; resp_delay = 0; cfg_stall = 0;
        raise(0, 20'h01010);
        start = step_no + 1;
        run_until_idle(20);
        total++; if (obs_addr !== 32'h8000_4040) $display("FAIL single_addr: got %h want 80004040", obs_addr); else passed++;
        total++; if (obs_we_step - start != 3) $display("FAIL single_latency: got %0d want 3", obs_we_step - start); else passed++;
        total++; if (obs_key !== 20'h01010 || obs_value !== 20'hAABA0) $display("FAIL single_kv: got %h/%h want 01010/aaba0", obs_key, obs_value); else passed++;
        total++; if (obs_done[0] != 1 || obs_done[1] != 0) $display("FAIL single_done: got %0d/%0d want 1/0", obs_done[0], obs_done[1]); else passed++;
        total++; if (obs_reads != 1 || obs_we != 1) $display("FAIL single_counts: got reads %0d we %0d want 1/1", obs_reads, obs_we); else passed++;
    endtask

    task automatic test_fault();
        clear_obs();
        force_data = 32'h1234_5000;
        raise(0, 20'h00ABC);
        run_until_idle(20);
        total++; if (obs_fault[0] != 1 || obs_fault[1] != 0) $display("FAIL fault_pulse: got %0d/%0d want 1/0", obs_fault[0], obs_fault[1]); else passed++;
        total++; if (obs_we != 0 || obs_done[0] != 0) $display("FAIL fault_no_write: got we %0d done %0d want 0/0", obs_we, obs_done[0]); else passed++;
    endtask

    // Fault walk above went to port 0, so the shared miss here goes to port 1.
    task automatic test_coalesce();
        clear_obs();
        force_data = 32'h0007_7001;
        raise(0, 20'hFFFFF); raise(1, 20'hFFFFF);
        run_until_idle(20);
        total++; if (obs_reads != 1) $display("FAIL coalesce_reads: got %0d want 1", obs_reads); else passed++;
        total++; if (obs_we != 1) $display("FAIL coalesce_writes: got %0d want 1", obs_we); else passed++;
        total++; if (obs_done_both != 1 || obs_done[0] != 1 || obs_done[1] != 1) $display("FAIL coalesce_done: got both %0d d0 %0d d1 %0d want 1/1/1", obs_done_both, obs_done[0], obs_done[1]); else passed++;
    endtask

    // Last grant is port 1 after the coalesced walk, so port 0 leads.
    task automatic test_fairness();
        clear_obs();
        force_data = 32'h00AB_C001;
        auto_rereq = 1;
        repeat (18) step();
        auto_rereq = 0;
        run_until_idle(40);
        total++;
        if (done_order.size() < 4) $display("FAIL fair_count: got %0d dones want >=4", done_order.size());
        else passed++;
        for (int i = 0; i < 4 && i < done_order.size(); i++) begin
            total++;
            if (done_order[i] != (i % 2)) $display("FAIL fair_order[%0d]: got port %0d want port %0d", i, done_order[i], i % 2);
            else passed++;
        end
    endtask

    task automatic test_backpressure_wrap();
        clear_obs();
        cfg_ptbr = 32'hFFFF_FFF0; cfg_stall = 5; force_data = 32'h0005_5001;
        raise(0, 20'h00008);
        run_until_idle(30);
        cfg_stall = 0;
        total++; if (obs_req_cycles != 6) $display("FAIL bp_req_cycles: got %0d want 6", obs_req_cycles); else passed++;
        total++; if (obs_addr !== 32'h0000_0010) $display("FAIL bp_wrap_addr: got %h want 00000010", obs_addr); else passed++;
        total++; if (obs_done[0] != 1 || obs_we != 1) $display("FAIL bp_complete: got done %0d we %0d want 1/1", obs_done[0], obs_we); else passed++;
    endtask

    task automatic test_random();
        clear_obs();
        force_en = 0; rand_mode = 1; stray_en = 1;
        repeat (400) step();
        rand_mode = 0; stray_en = 0;
        run_until_idle(100);
        total++; if (obs_reads < 10) $display("FAIL random_activity: got %0d reads want >=10", obs_reads); else passed++;
    endtask

    task automatic test_reset_mid_wait();
        clear_obs();
        force_en = 1; force_data = 32'h0001_2001; cfg_ptbr = 32'h0000_1000; resp_delay = 10;
        raise(0, 20'h00042);
        for (int i = 0; i < 10; i++) begin
            if (armed) break;
            step();
        end
        step();
        #1 rst = 1'b0;
        #1;
        total++; if (mem_req_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_wait_idle: got req %b busy %b want 0/0", mem_req_valid, busy); else passed++;
        total++; if (tlb_write_enable !== 1'b0 || miss_done[0] !== 1'b0 || miss_fault[0] !== 1'b0) $display("FAIL rst_wait_pulses: got we %b d %b f %b want 0", tlb_write_enable, miss_done[0], miss_fault[0]); else passed++;
        model_reset();
        resp_delay = 0;
        force_stray = 1;
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        force_stray = 0;
        clear_obs();
        raise(0, 20'h00100); raise(1, 20'h00200);
        run_until_idle(30);
        total++;
        if (done_order.size() == 0) $display("FAIL rst_next_grant: got no done want port 0");
        else if (done_order[0] != 0) $display("FAIL rst_next_grant: got port %0d want port 0", done_order[0]);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_miss();
        test_fault();
        test_coalesce();
        test_fairness();
        test_backpressure_wrap();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
